serial_subtractor_ctrl: RTL
===========================

Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor. The controller sequences one internal full_subtractor instance (ports a, b, bin, diff, borrow) LSB-first over WIDTH cycles. It computes diff = a - b - bin_in and reports the final borrow. Uses a start/busy/done handshake, so a shared datapath or testbench can issue operations without building a ripple chain of WIDTH full_subtractors.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled on accepting edge
b  input  WIDTH  subtrahend; sampled on accepting edge
bin_in  input  1  initial borrow-in; sampled on accepting edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
diff  output  WIDTH  result; held until next completion
borrow_out  output  1  final borrow; held until next completion

Behaviour:
- Reset (rst=1 at rising edge), dominant over all other inputs:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow_out=0
  - internal shift registers, borrow flop and bit counter cleared
- Interface: one clock (clk), reset synchronous and active-high (rst).
- States IDLE, RUN, DONE. State is registered; busy and done are decoded from state.
- IDLE:
  - if start=1 at edge E0: load a_sr<=a, b_sr<=b, brw<=bin_in, cnt<=0, state->RUN.
  - otherwise stay in IDLE.
- RUN, each edge:
  - full_subtractor inputs: a=a_sr[0], b=b_sr[0], bin=brw.
  - res_sr shifts right, fs diff enters at MSB.
  - a_sr and b_sr shift right.
  - brw<=fs borrow; cnt<=cnt+1.
  - when cnt==WIDTH-1 on that edge:
    - diff<=final res_sr
    - borrow_out<=fs borrow
    - state->DONE
- DONE: done=1 for exactly one cycle; next edge state->IDLE unconditionally.
- Timing:
  - done high during the cycle following edge E_WIDTH.
  - busy high from E0 through E_WIDTH+1, i.e. WIDTH+1 cycles.
  - minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued. start held high continuously triggers a new operation every WIDTH+2 cycles.
- a, b and bin_in may change freely after E0; the operation uses the latched values.
- diff and borrow_out change only at the completion edge. Earlier results stay stable through IDLE and during the next RUN.
- Arithmetic is modulo 2^WIDTH. borrow_out=1 iff a < b+bin_in (unsigned).
- cnt is wide enough for WIDTH-1; no wrap occurs within an operation.
- rst during RUN or DONE aborts the operation: outputs cleared at that edge, and done does not pulse for the aborted operation.

Optional Feature:
SUB_SIGNED_OVF_EN
- Defined:
  - adds output port ovf (1 bit), reset 0.
  - at the completion edge, ovf<=(a_msb ^ b_msb) & (res_msb ^ a_msb), using latched operand MSBs and the final result MSB.
  - ovf is held with diff until the next completion.
- Not defined: port ovf absent, no added logic; all other behaviour identical.

Test Plan:
1. rst=1 two cycles, then rst=0 with start=0 -> busy=0, done=0, diff=0x00, borrow_out=0, stays IDLE.
2. WIDTH=8, a=0x5A, b=0x3C, bin_in=0, start pulse at E0 -> done high exactly after E8 for one cycle, diff=0x1E, borrow_out=0, busy high 9 cycles.
3. a=0x10, b=0x20, bin_in=0 -> diff=0xF0, borrow_out=1. Then a=0x00, b=0x00, bin_in=1 -> diff=0xFF, borrow_out=1.
4. Accept a=0x05, b=0x03; pulse start at E3 with a=0xFF, b=0x00 -> second request ignored, diff=0x02, only one done pulse. start held high -> done pulses every 10 cycles.
5. Accept a=0x5A, b=0x3C; assert rst at E3 -> busy=0, diff=0x00 next cycle, no done pulse. New start after reset completes normally with diff=0x1E.
6. With SUB_SIGNED_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1. a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1. a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a - b - bin_in using one full_subtractor, LSB first.
// Define SUB_SIGNED_OVF_EN to add the signed-overflow output ovf.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ bin;
    assign borrow = (~a & (b | bin)) | (b & bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
    ,output logic            ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d, borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fs_diff, fs_borrow;
    logic [WIDTH-1:0] res_next;
`ifdef SUB_SIGNED_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a      (a_sr_q[0]),
        .b      (b_sr_q[0]),
        .bin    (brw_q),
        .diff   (fs_diff),
        .borrow (fs_borrow)
    );

    assign res_next = {fs_diff, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                a_sr_d  = a;
                b_sr_d  = b;
                brw_d   = bin_in;
                cnt_d   = '0;
                state_d = RUN;
`ifdef SUB_SIGNED_OVF_EN
                a_msb_d = a[WIDTH-1];
                b_msb_d = b[WIDTH-1];
`endif
            end
            RUN: begin
                res_sr_d = res_next;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                brw_d    = fs_borrow;
                cnt_d    = cnt_q + 1'b1;
                // Last bit: publish the result including the bit computed this cycle.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_next;
                    borrow_d = fs_borrow;
                    state_d  = DONE;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (fs_diff ^ a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif
endmodule
